// File: rtl/wb_arbiter.sv
// Two-master to one-slave bus arbiter. Masters request with Mx_cs and hold it
// until their ack. The owner's bus is forwarded combinationally to the slave.
// Ties between masters go to the one not served last. A per-grant wait counter
// forces an error completion when the slave does not ack in time.
//
// Handshake: a master raises Mx_cs and holds it until it samples Mx_ack high
// at a rising edge. Mx_ack is a single-cycle strobe. Mx_err is only ever high
// together with Mx_ack. The slave completes a cycle by raising S_ack while
// S_cs is high. S_ack is ignored whenever S_cs is low.

`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [`ADDR_SIZE-1:0]   M0_addr,
    input  logic                    M0_cs,
    input  logic                    M0_we,
    input  logic [`WORD_SIZE-1:0]   M0_wdata,
    output logic [`WORD_SIZE-1:0]   M0_rdata,
    output logic                    M0_ack,
    output logic                    M0_err,
    input  logic [`ADDR_SIZE-1:0]   M1_addr,
    input  logic                    M1_cs,
    input  logic                    M1_we,
    input  logic [`WORD_SIZE-1:0]   M1_wdata,
    output logic [`WORD_SIZE-1:0]   M1_rdata,
    output logic                    M1_ack,
    output logic                    M1_err,
    output logic [`ADDR_SIZE-1:0]   S_addr,
    output logic                    S_cs,
    output logic                    S_we,
    output logic [`WORD_SIZE-1:0]   S_wdata,
    input  logic [`WORD_SIZE-1:0]   S_rdata,
    input  logic                    S_ack,
    output logic [1:0]              Gnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    // Last counter value of a grant before the forced error completion.
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_last_m1;   // 1: M1 was served last, so M0 wins the next tie

    logic       w_granted;
    logic       w_sel1;
    logic       w_own_cs;
    logic       w_oth_cs;
    logic       w_live;
    logic       w_timeout;
    logic       w_done;

    assign w_granted = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);
    assign w_sel1    = (r_state == ST_GRANT1);
    assign w_own_cs  = w_sel1 ? M1_cs : M0_cs;
    assign w_oth_cs  = w_sel1 ? M0_cs : M1_cs;
    // Owner still holding its request; a dropped request gets no completion.
    assign w_live    = w_granted && w_own_cs;
    // Slave ack in the last allowed cycle beats the timeout.
    assign w_timeout = w_live && !S_ack && (r_cnt == LP_TO_LAST);
    assign w_done    = w_live && (S_ack || w_timeout);

    // Bus steering: forward the owner's request and route the response back.
    always_comb begin
        S_addr   = '0;
        S_cs     = 1'b0;
        S_we     = 1'b0;
        S_wdata  = '0;
        M0_rdata = '0;
        M0_ack   = 1'b0;
        M0_err   = 1'b0;
        M1_rdata = '0;
        M1_ack   = 1'b0;
        M1_err   = 1'b0;
        if (w_granted) begin
            S_addr  = w_sel1 ? M1_addr  : M0_addr;
            S_we    = w_sel1 ? M1_we    : M0_we;
            S_wdata = w_sel1 ? M1_wdata : M0_wdata;
            S_cs    = w_live && !w_timeout;
            if (w_sel1) begin
                M1_ack   = w_done;
                M1_err   = w_timeout;
                M1_rdata = (w_live && !w_timeout) ? S_rdata : '0;
            end else begin
                M0_ack   = w_done;
                M0_err   = w_timeout;
                M0_rdata = (w_live && !w_timeout) ? S_rdata : '0;
            end
        end
    end

    // Grant indication is a straight decode of the registered state.
    assign Gnt = {r_state == ST_GRANT1, r_state == ST_GRANT0};

    // Arbitration state, wait counter and round-robin pointer.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_last_m1 <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 8'd0;
                    if (M0_cs && M1_cs) begin
                        r_state <= r_last_m1 ? ST_GRANT0 : ST_GRANT1;
                    end else if (M0_cs) begin
                        r_state <= ST_GRANT0;
                    end else if (M1_cs) begin
                        r_state <= ST_GRANT1;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    if (!w_own_cs) begin
                        // Abandoned by the owner: count it as served, go idle.
                        r_state   <= ST_IDLE;
                        r_cnt     <= 8'd0;
                        r_last_m1 <= w_sel1;
                    end else if (w_done) begin
                        r_last_m1 <= w_sel1;
                        r_cnt     <= 8'd0;
                        if (w_oth_cs) begin
                            r_state <= w_sel1 ? ST_GRANT0 : ST_GRANT1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration rules.

`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_wb_arbiter;

    localparam int TO = 16;
    localparam int AW = `ADDR_SIZE;
    localparam int DW = `WORD_SIZE;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [AW-1:0] M0_addr, M1_addr, S_addr;
    logic          M0_cs, M1_cs, M0_we, M1_we;
    logic [DW-1:0] M0_wdata, M1_wdata, M0_rdata, M1_rdata;
    logic          M0_ack, M1_ack, M0_err, M1_err;
    logic          S_cs, S_we, S_ack;
    logic [DW-1:0] S_wdata, S_rdata;
    logic [1:0]    Gnt;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk), .Rst(Rst),
        .M0_addr(M0_addr), .M0_cs(M0_cs), .M0_we(M0_we), .M0_wdata(M0_wdata),
        .M0_rdata(M0_rdata), .M0_ack(M0_ack), .M0_err(M0_err),
        .M1_addr(M1_addr), .M1_cs(M1_cs), .M1_we(M1_we), .M1_wdata(M1_wdata),
        .M1_rdata(M1_rdata), .M1_ack(M1_ack), .M1_err(M1_err),
        .S_addr(S_addr), .S_cs(S_cs), .S_we(S_we), .S_wdata(S_wdata),
        .S_rdata(S_rdata), .S_ack(S_ack), .Gnt(Gnt)
    );

    // Clock and reset block
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic next_cycle;
        @(posedge Clk);
        #1;
    endtask

    task automatic to_sample;
        @(negedge Clk);
    endtask

    task automatic drive_idle;
        M0_addr = '0; M0_cs = 1'b0; M0_we = 1'b0; M0_wdata = '0;
        M1_addr = '0; M1_cs = 1'b0; M1_we = 1'b0; M1_wdata = '0;
        S_ack = 1'b0; S_rdata = '0;
    endtask

    task automatic do_reset;
        Rst = 1'b1;
        drive_idle();
        next_cycle();
        Rst = 1'b0;
    endtask

    // Reset state: everything zero even with requests and a stray slave ack
    task automatic test_reset;
        logic [6:0] act;
        Rst = 1'b1;
        drive_idle();
        M0_cs = 1'b1; M1_cs = 1'b1; M0_addr = AW'($urandom); M1_wdata = DW'($urandom);
        S_ack = 1'b1; S_rdata = DW'($urandom);
        next_cycle();
        next_cycle();
        to_sample();
        act = {Gnt, S_cs, M0_ack, M1_ack, M0_err, M1_err};
        checks++; if (act !== 7'd0) begin errors++; $display("FAIL reset_ctrl got=%h exp=%h", act, 7'd0); end
        checks++; if ({S_addr, S_we, S_wdata, M0_rdata, M1_rdata} !== '0) begin errors++;
            $display("FAIL reset_data got=%h/%h/%h exp=0", S_addr, M0_rdata, M1_rdata); end
        next_cycle();
        Rst = 1'b0;
        drive_idle();
        next_cycle();
    endtask

    // Single M0 read, slave responds after two wait cycles
    task automatic test_single_read;
        do_reset();
        M0_cs = 1'b1; M0_addr = AW'(32'h10); M0_we = 1'b0; M0_wdata = DW'($urandom);
        to_sample();
        checks++; if ({Gnt, S_cs} !== 3'b000) begin errors++; $display("FAIL read_latency got=%b exp=000", {Gnt, S_cs}); end
        next_cycle();
        for (int w = 0; w < 2; w++) begin
            to_sample();
            checks++; if ({Gnt, S_cs, S_we, M0_ack} !== 5'b01100 || S_addr !== AW'(32'h10)) begin errors++;
                $display("FAIL read_wait got=%b/%h exp=01100/10", {Gnt, S_cs, S_we, M0_ack}, S_addr); end
            next_cycle();
        end
        S_ack = 1'b1; S_rdata = DW'(32'hDEADBEEF);
        to_sample();
        checks++; if ({M0_ack, M0_err, M1_ack} !== 3'b100) begin errors++;
            $display("FAIL read_ack got=%b exp=100", {M0_ack, M0_err, M1_ack}); end
        checks++; if (M0_rdata !== DW'(32'hDEADBEEF)) begin errors++;
            $display("FAIL read_rdata got=%h exp=deadbeef", M0_rdata); end
        next_cycle();
        M0_cs = 1'b0; S_ack = 1'b0;
        to_sample();
        checks++; if ({Gnt, M0_ack} !== 3'b000) begin errors++; $display("FAIL read_idle got=%b exp=000", {Gnt, M0_ack}); end
        next_cycle();
    endtask

    // Simultaneous requests from reset: M0 first, then direct handoff to M1
    task automatic test_tie;
        logic [DW-1:0] r0, r1;
        r0 = DW'($urandom); r1 = DW'($urandom);
        do_reset();
        M0_cs = 1'b1; M1_cs = 1'b1; M0_addr = AW'($urandom); M1_addr = AW'($urandom);
        to_sample();
        checks++; if (Gnt !== 2'b00) begin errors++; $display("FAIL tie_idle got=%b exp=00", Gnt); end
        next_cycle();
        S_ack = 1'b1; S_rdata = r0;
        to_sample();
        checks++; if ({Gnt, M0_ack, M1_ack} !== 4'b0110 || M0_rdata !== r0 || M1_rdata !== '0) begin errors++;
            $display("FAIL tie_first got=%b/%h exp=0110/%h", {Gnt, M0_ack, M1_ack}, M0_rdata, r0); end
        next_cycle();
        M0_cs = 1'b0; S_rdata = r1;
        to_sample();
        checks++; if ({Gnt, M0_ack, M1_ack} !== 4'b1001 || M1_rdata !== r1 || S_addr !== M1_addr) begin errors++;
            $display("FAIL tie_second got=%b/%h exp=1001/%h", {Gnt, M0_ack, M1_ack}, M1_rdata, r1); end
        next_cycle();
        M1_cs = 1'b0; S_ack = 1'b0;
        to_sample();
        checks++; if (Gnt !== 2'b00) begin errors++; $display("FAIL tie_end got=%b exp=00", Gnt); end
        next_cycle();
    endtask

    // Continuous requests from both: grants must alternate 0,1,0,1,0,1
    task automatic test_back_to_back;
        int a0, a1, delay;
        logic [1:0] exp;
        a0 = 0; a1 = 0;
        do_reset();
        exp_q = {2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        M0_cs = 1'b1; M1_cs = 1'b1;
        to_sample();
        next_cycle();
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            delay = $urandom_range(0, 2);
            for (int d = 0; d <= delay; d++) begin
                S_ack = (d == delay); S_rdata = DW'($urandom);
                to_sample();
                checks++; if (Gnt !== exp) begin errors++; $display("FAIL alt_gnt got=%b exp=%b", Gnt, exp); end
                checks++; if ({M1_ack, M0_ack} !== ((d == delay) ? exp : 2'b00)) begin errors++;
                    $display("FAIL alt_ack got=%b exp=%b", {M1_ack, M0_ack}, (d == delay) ? exp : 2'b00); end
                next_cycle();
            end
            if (exp == 2'b01) a0++; else a1++;
            if (a0 == 3) M0_cs = 1'b0;
            if (a1 == 3) M1_cs = 1'b0;
        end
        S_ack = 1'b0;
        to_sample();
        checks++; if (Gnt !== 2'b00) begin errors++; $display("FAIL alt_end got=%b exp=00", Gnt); end
        next_cycle();
    endtask

    // M1 write with a silent slave, then M0 read acked exactly at the limit
    task automatic test_timeout;
        logic [DW-1:0] rd;
        do_reset();
        M1_cs = 1'b1; M1_addr = AW'(32'h20); M1_we = 1'b1; M1_wdata = DW'(32'h12345678);
        S_rdata = DW'($urandom) | DW'(1);
        to_sample();
        next_cycle();
        for (int i = 0; i < TO; i++) begin
            to_sample();
            checks++; if ({Gnt, S_we, M0_ack} !== 4'b1010 || S_wdata !== DW'(32'h12345678) || S_addr !== AW'(32'h20)) begin
                errors++; $display("FAIL to_bus got=%b/%h/%h exp=1010/12345678/20", {Gnt, S_we, M0_ack}, S_wdata, S_addr); end
            if (i < TO - 1) begin
                checks++; if ({S_cs, M1_ack, M1_err} !== 3'b100) begin errors++;
                    $display("FAIL to_wait cycle=%0d got=%b exp=100", i, {S_cs, M1_ack, M1_err}); end
            end else begin
                checks++; if ({S_cs, M1_ack, M1_err} !== 3'b011 || M1_rdata !== '0) begin errors++;
                    $display("FAIL to_fire got=%b/%h exp=011/0", {S_cs, M1_ack, M1_err}, M1_rdata); end
            end
            next_cycle();
        end
        M1_cs = 1'b0;
        to_sample();
        checks++; if (Gnt !== 2'b00) begin errors++; $display("FAIL to_idle got=%b exp=00", Gnt); end
        next_cycle();
        rd = DW'($urandom);
        M0_cs = 1'b1; M0_addr = AW'($urandom); M0_we = 1'b0;
        next_cycle();
        for (int i = 0; i < TO; i++) begin
            S_ack = (i == TO - 1); S_rdata = rd;
            to_sample();
            if (i == TO - 1) begin
                checks++; if ({M0_ack, M0_err, S_cs} !== 3'b101 || M0_rdata !== rd) begin errors++;
                    $display("FAIL to_ack_wins got=%b/%h exp=101/%h", {M0_ack, M0_err, S_cs}, M0_rdata, rd); end
            end
            next_cycle();
        end
        M0_cs = 1'b0; S_ack = 1'b0;
        next_cycle();
    endtask

    // Reset in the third wait cycle of an M0 read, then a fresh read
    task automatic test_reset_mid;
        logic [DW-1:0] rd;
        do_reset();
        M0_cs = 1'b1; M0_addr = AW'($urandom); M0_we = 1'b0;
        next_cycle();
        for (int w = 1; w <= 3; w++) begin
            if (w == 3) Rst = 1'b1;
            to_sample();
            checks++; if ({Gnt, M0_ack} !== 3'b010) begin errors++; $display("FAIL rmid_wait got=%b exp=010", {Gnt, M0_ack}); end
            next_cycle();
        end
        Rst = 1'b0; M0_cs = 1'b0; S_ack = 1'b1;
        to_sample();
        checks++; if ({Gnt, S_cs, M0_ack, M0_err, M1_ack} !== 6'd0) begin errors++;
            $display("FAIL rmid_abandon got=%b exp=000000", {Gnt, S_cs, M0_ack, M0_err, M1_ack}); end
        next_cycle();
        rd = DW'($urandom);
        M0_cs = 1'b1; S_ack = 1'b0;
        next_cycle();
        S_ack = 1'b1; S_rdata = rd;
        to_sample();
        checks++; if ({Gnt, M0_ack, M0_err} !== 4'b0110 || M0_rdata !== rd) begin errors++;
            $display("FAIL rmid_fresh got=%b/%h exp=0110/%h", {Gnt, M0_ack, M0_err}, M0_rdata, rd); end
        next_cycle();
        M0_cs = 1'b0; S_ack = 1'b0;
        next_cycle();
    endtask

    // Owner M0 abandons after one wait cycle while M1 is pending
    task automatic test_drop;
        do_reset();
        M0_cs = 1'b1; M0_addr = AW'($urandom);
        next_cycle();
        M1_cs = 1'b1; M1_addr = AW'($urandom);
        to_sample();
        checks++; if ({Gnt, S_cs} !== 3'b011) begin errors++; $display("FAIL drop_grant got=%b exp=011", {Gnt, S_cs}); end
        next_cycle();
        M0_cs = 1'b0; S_ack = 1'b1;
        to_sample();
        checks++; if ({Gnt, S_cs, M0_ack, M0_err, M1_ack} !== 6'b010000) begin errors++;
            $display("FAIL drop_cycle got=%b exp=010000", {Gnt, S_cs, M0_ack, M0_err, M1_ack}); end
        next_cycle();
        to_sample();
        checks++; if ({Gnt, S_cs, M0_ack, M1_ack} !== 5'd0) begin errors++;
            $display("FAIL drop_idle got=%b exp=00000", {Gnt, S_cs, M0_ack, M1_ack}); end
        next_cycle();
        to_sample();
        checks++; if ({Gnt, S_cs, M1_ack} !== 4'b1011 || S_addr !== M1_addr) begin errors++;
            $display("FAIL drop_m1 got=%b exp=1011", {Gnt, S_cs, M1_ack}); end
        next_cycle();
        M1_cs = 1'b0; S_ack = 1'b0;
        next_cycle();
    endtask

    // Randomized traffic against a transaction-level reference model
    task automatic test_random;
        int owner, waited, last, pct;
        logic          cs_v[2];
        logic [AW-1:0] ad_v[2];
        logic          we_v[2];
        logic [DW-1:0] wd_v[2];
        logic          acked[2];
        logic          tmo, eack, escs;
        logic [1:0]    egnt;
        logic [6:0]    act, exp;
        do_reset();
        owner = -1; waited = 0; last = 1;
        for (int m = 0; m < 2; m++) begin
            cs_v[m] = 1'b0; acked[m] = 1'b0; ad_v[m] = '0; we_v[m] = 1'b0; wd_v[m] = '0;
        end
        for (int n = 0; n < 600; n++) begin
            pct = (n < 300) ? 40 : 5;
            for (int m = 0; m < 2; m++) begin
                if (acked[m] || !cs_v[m]) begin
                    cs_v[m] = acked[m] ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
                    ad_v[m] = AW'($urandom); we_v[m] = 1'($urandom); wd_v[m] = DW'($urandom);
                end
            end
            M0_cs = cs_v[0]; M0_addr = ad_v[0]; M0_we = we_v[0]; M0_wdata = wd_v[0];
            M1_cs = cs_v[1]; M1_addr = ad_v[1]; M1_we = we_v[1]; M1_wdata = wd_v[1];
            S_ack = ($urandom_range(0, 99) < pct); S_rdata = DW'($urandom);
            egnt = 2'b00; escs = 1'b0; eack = 1'b0; tmo = 1'b0;
            if (owner >= 0) begin
                egnt = (owner == 0) ? 2'b01 : 2'b10;
                tmo  = cs_v[owner] && !S_ack && (waited == TO - 1);
                escs = cs_v[owner] && !tmo;
                eack = cs_v[owner] && (S_ack || tmo);
            end
            exp = {egnt, escs, (owner == 1) && eack, (owner == 0) && eack, (owner == 1) && tmo, (owner == 0) && tmo};
            to_sample();
            act = {Gnt, S_cs, M1_ack, M0_ack, M1_err, M0_err};
            checks++; if (act !== exp) begin errors++; $display("FAIL rand_ctrl n=%0d got=%b exp=%b", n, act, exp); end
            if (owner >= 0) begin
                checks++; if (S_addr !== ad_v[owner] || S_we !== we_v[owner] || S_wdata !== wd_v[owner]) begin errors++;
                    $display("FAIL rand_bus n=%0d got=%h exp=%h", n, S_addr, ad_v[owner]); end
                if (eack) begin
                    checks++; if (((owner == 0) ? M0_rdata : M1_rdata) !== (tmo ? '0 : S_rdata)) begin errors++;
                        $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, (owner == 0) ? M0_rdata : M1_rdata, tmo ? '0 : S_rdata); end
                end
                checks++; if (((owner == 0) ? M1_rdata : M0_rdata) !== '0) begin errors++;
                    $display("FAIL rand_other_rdata n=%0d got=%h exp=0", n, (owner == 0) ? M1_rdata : M0_rdata); end
            end
            next_cycle();
            acked[0] = (owner == 0) && eack;
            acked[1] = (owner == 1) && eack;
            if (owner >= 0) begin
                if (!cs_v[owner]) begin
                    last = owner; owner = -1; waited = 0;
                end else if (eack) begin
                    last = owner; waited = 0;
                    owner = cs_v[1 - owner] ? 1 - owner : -1;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
                if (cs_v[0] && cs_v[1]) owner = (last == 1) ? 0 : 1;
                else if (cs_v[0]) owner = 0;
                else if (cs_v[1]) owner = 1;
            end
        end
        drive_idle();
        next_cycle();
    endtask

    initial begin
        Rst = 1'b1;
        drive_idle();
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
